// File: rtl/arcade_input_conditioner_if.sv
// Event drain port for the arcade input conditioner: one press/release event
// per valid/ready transfer.
interface arcade_input_conditioner_if #(
    parameter int unsigned CHAN_W = 5
) ();
    logic              event_valid;
    logic              event_ready;
    logic [CHAN_W-1:0] event_chan;
    logic              event_press;

    modport master (
        output event_valid,
        output event_chan,
        output event_press,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_chan,
        input  event_press,
        output event_ready
    );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Per-channel synchronise / polarity-correct / debounce / edge-detect for arcade
// buttons, with LED mirror and a pending-bit event queue drained over valid/ready.
module arcade_input_conditioner #(
    parameter int unsigned CHANNELS        = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CHAN_W          = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_pin_in,
    output logic [CHANNELS-1:0] o_state_out,
    output logic [CHANNELS-1:0] o_led,
    output logic [CHANNELS-1:0] o_press_pulse,
    output logic [CHANNELS-1:0] o_release_pulse,
    output logic                o_overflow,
    arcade_input_conditioner_if.master evt
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] w_norm;
    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

    logic [CNT_W-1:0]    r_cnt     [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_state;
    logic [CHANNELS-1:0] w_state_nxt;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] r_press_pulse;
    logic [CHANNELS-1:0] r_release_pulse;

    logic [CHANNELS-1:0] r_pend_press;
    logic [CHANNELS-1:0] r_pend_release;
    logic [CHANNELS-1:0] w_pend_any;
    logic [CHANNELS-1:0] w_sel_onehot;
    logic [CHANNELS-1:0] w_clr_press;
    logic [CHANNELS-1:0] w_clr_release;
    logic [CHAN_W-1:0]   w_sel_idx;
    logic                w_sel_found;
    logic                w_sel_press;
    logic                w_load;
    logic                w_ovf_set;

    logic                r_evt_valid;
    logic [CHAN_W-1:0]   r_evt_chan;
    logic                r_evt_press;
    logic                r_overflow;

    // Normalise so that 1 always means pressed, then synchronise
    assign w_norm = ACTIVE_LOW ? ~i_pin_in : i_pin_in;
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= w_norm;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Debounce: a new level must persist for DEBOUNCE_CYCLES synced cycles
    always_comb begin
        w_state_nxt = r_state;
        w_rise      = '0;
        w_fall      = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_sync[i] == r_state[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i]   = '0;
                w_state_nxt[i] = w_sync[i];
                w_rise[i]      = w_sync[i];
                w_fall[i]      = ~w_sync[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= '0;
            end
            r_state         <= '0;
            r_press_pulse   <= '0;
            r_release_pulse <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_state         <= w_state_nxt;
            r_press_pulse   <= w_rise;
            r_release_pulse <= w_fall;
        end
    end

    // Lowest pending channel wins; press beats release within a channel
    assign w_pend_any = r_pend_press | r_pend_release;
    assign w_load     = ~r_evt_valid | evt.event_ready;

    always_comb begin
        w_sel_idx    = '0;
        w_sel_found  = 1'b0;
        w_sel_press  = 1'b0;
        w_sel_onehot = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (w_pend_any[i]) begin
                w_sel_idx       = CHAN_W'(i);
                w_sel_found     = 1'b1;
                w_sel_press     = r_pend_press[i];
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_clr_press   = (w_load && w_sel_found &&  w_sel_press) ? w_sel_onehot : '0;
    assign w_clr_release = (w_load && w_sel_found && !w_sel_press) ? w_sel_onehot : '0;
    assign w_ovf_set     = |(w_rise & r_pend_press   & ~w_clr_press) |
                           |(w_fall & r_pend_release & ~w_clr_release);

    // Set wins over a same-edge clear so a fresh edge is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_press   <= '0;
            r_pend_release <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_pend_press   <= (r_pend_press   & ~w_clr_press)   | w_rise;
            r_pend_release <= (r_pend_release & ~w_clr_release) | w_fall;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output event stage; chan/press hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_press <= 1'b0;
        end else if (w_load) begin
            r_evt_valid <= w_sel_found;
            if (w_sel_found) begin
                r_evt_chan  <= w_sel_idx;
                r_evt_press <= w_sel_press;
            end
        end
    end

    assign o_state_out     = r_state;
    assign o_led           = r_state;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_overflow      = r_overflow;

    assign evt.event_valid = r_evt_valid;
    assign evt.event_chan  = r_evt_chan;
    assign evt.event_press = r_evt_press;
endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner with an event scoreboard
// (CHANNELS=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
module tb_arcade_input_conditioner;
    typedef struct packed {
        logic [4:0] chan;
        logic       press;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pin_in;
    logic [15:0] state_out;
    logic [15:0] led;
    logic [15:0] press_pulse;
    logic [15:0] release_pulse;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    ev_t sb[$];

    arcade_input_conditioner_if #(.CHAN_W(5)) evt_if ();

    arcade_input_conditioner #(
        .CHANNELS        (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1),
        .CHAN_W          (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_pin_in        (pin_in),
        .o_state_out     (state_out),
        .o_led           (led),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse),
        .o_overflow      (overflow),
        .evt             (evt_if.master)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the offered event against the scoreboard head and consume it
    task automatic expect_xfer(input string tag);
        ev_t e;
        chk({tag, ".valid"}, 32'(evt_if.event_valid), 32'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.sb observed=event expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".chan"},  32'(evt_if.event_chan),  32'(e.chan));
            chk({tag, ".press"}, 32'(evt_if.event_press), 32'(e.press));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 32'(state_out), 32'h0);
        chk({tag, ".led"},   32'(led),       32'h0);
        chk({tag, ".valid"}, 32'(evt_if.event_valid), 32'd0);
        chk({tag, ".ovf"},   32'(overflow),  32'd0);
    endtask

    initial begin
        reset              = 1'b1;
        pin_in             = 16'hFFFF;
        evt_if.event_ready = 1'b0;

        // Reset with all switches released
        step(3);
        chk_idle("rst");
        chk("rst.ppulse", 32'(press_pulse),   32'h0);
        chk("rst.rpulse", 32'(release_pulse), 32'h0);
        reset = 1'b0;
        step(3);
        chk_idle("post_rst");

        // Clean press on ch3: state at edge 6, event at edge 7
        evt_if.event_ready = 1'b1;
        pin_in[3] = 1'b0;
        sb.push_back('{chan: 5'd3, press: 1'b1});
        step(5);
        chk("ch3.e5.state", 32'(state_out), 32'h0);
        step(1);
        chk("ch3.e6.state",  32'(state_out),   32'h0008);
        chk("ch3.e6.led",    32'(led),         32'h0008);
        chk("ch3.e6.ppulse", 32'(press_pulse), 32'h0008);
        chk("ch3.e6.valid",  32'(evt_if.event_valid), 32'd0);
        step(1);
        chk("ch3.e7.ppulse", 32'(press_pulse), 32'h0);
        expect_xfer("ch3.e7");
        step(1);
        chk("ch3.e8.valid", 32'(evt_if.event_valid), 32'd0);

        // Bounce on ch0: low 3, high 1, low held -> accepted at edge 10
        pin_in[0] = 1'b0;
        step(3);
        pin_in[0] = 1'b1;
        step(1);
        pin_in[0] = 1'b0;
        sb.push_back('{chan: 5'd0, press: 1'b1});
        step(2);
        chk("bnc.e6.state", 32'(state_out), 32'h0008);
        step(3);
        chk("bnc.e9.state", 32'(state_out), 32'h0008);
        step(1);
        chk("bnc.e10.state",  32'(state_out),   32'h0009);
        chk("bnc.e10.ppulse", 32'(press_pulse), 32'h0001);
        step(1);
        expect_xfer("bnc.e11");
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("bnc.once.valid", 32'(evt_if.event_valid), 32'd0);
        end

        // Simultaneous press ch5 + ch2 while stalled
        evt_if.event_ready = 1'b0;
        pin_in[5] = 1'b0;
        pin_in[2] = 1'b0;
        sb.push_back('{chan: 5'd2, press: 1'b1});
        sb.push_back('{chan: 5'd5, press: 1'b1});
        step(6);
        chk("sim.e6.state", 32'(state_out),   32'h002D);
        chk("sim.e6.ppulse", 32'(press_pulse), 32'h0024);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("sim.hold.valid", 32'(evt_if.event_valid), 32'd1);
            chk("sim.hold.chan",  32'(evt_if.event_chan),  32'(sb[0].chan));
        end
        evt_if.event_ready = 1'b1;
        expect_xfer("sim.x2");
        step(1);
        expect_xfer("sim.x5");
        step(1);
        chk("sim.empty.valid", 32'(evt_if.event_valid), 32'd0);

        // Occupy the stage with a ch0 release, then ch1 press/release/press merges
        evt_if.event_ready = 1'b0;
        pin_in[0] = 1'b1;
        sb.push_back('{chan: 5'd0, press: 1'b0});
        step(6);
        chk("rel0.rpulse", 32'(release_pulse), 32'h0001);
        chk("rel0.ppulse", 32'(press_pulse),   32'h0);
        step(1);
        chk("rel0.valid", 32'(evt_if.event_valid), 32'd1);
        chk("rel0.chan",  32'(evt_if.event_chan),  32'd0);
        pin_in[1] = 1'b0;
        sb.push_back('{chan: 5'd1, press: 1'b1});
        step(6);
        chk("ovf.p1.state", 32'(state_out), 32'h002E);
        pin_in[1] = 1'b1;
        sb.push_back('{chan: 5'd1, press: 1'b0});
        step(6);
        chk("ovf.r1.rpulse", 32'(release_pulse), 32'h0002);
        chk("ovf.r1.ovf",    32'(overflow),      32'd0);
        pin_in[1] = 1'b0;
        step(6);
        chk("ovf.p2.state", 32'(state_out), 32'h002E);
        step(1);
        chk("ovf.p2.ovf",   32'(overflow),  32'd1);
        evt_if.event_ready = 1'b1;
        expect_xfer("drain.r0");
        step(1);
        expect_xfer("drain.p1");
        step(1);
        expect_xfer("drain.r1");
        step(1);
        chk("drain.empty.valid", 32'(evt_if.event_valid), 32'd0);
        chk("drain.ovf_sticky",  32'(overflow),           32'd1);

        // Reset with an event held and a count in flight
        evt_if.event_ready = 1'b0;
        pin_in[2] = 1'b1;
        step(7);
        chk("mid.held.valid", 32'(evt_if.event_valid), 32'd1);
        chk("mid.held.chan",  32'(evt_if.event_chan),  32'd2);
        chk("mid.held.press", 32'(evt_if.event_press), 32'd0);
        pin_in[5] = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        chk_idle("mid.rst");
        chk("mid.rst.ppulse", 32'(press_pulse),   32'h0);
        chk("mid.rst.rpulse", 32'(release_pulse), 32'h0);
        pin_in = 16'hFFFF;
        step(2);
        reset = 1'b0;
        evt_if.event_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("post.valid",  32'(evt_if.event_valid), 32'd0);
            chk("post.rpulse", 32'(release_pulse),      32'h0);
        end
        chk_idle("post.final");
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
